fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences instruction fetch from the instruction memory (IM) for the CPU.
- Owns the PC register, issues one-word fetch requests to IM with a req/ack handshake, and presents each fetched instruction to decode with a valid/ready handshake.
- Accepts branch/jump redirects and halt requests.
- Range-checks every fetch address against the IM window; an out-of-window address traps to a sticky error state.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest byte address mapped by IM.
- IM_WORDS, 4096, number of 32-bit words in IM; the window is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- im_req  out  1  fetch request to IM.
- im_addr  out  32  byte address of the fetch; equals pc.
- im_ack  in  1  IM has valid data for im_addr in this cycle.
- im_rdata  in  32  instruction word from IM; valid only when im_ack=1.
- redirect_valid  in  1  branch/jump/jr taken; 1-cycle pulse.
- redirect_target  in  32  new PC for the redirect.
- halt  in  1  stop fetching; sticky once accepted.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- halted  out  1  controller is in HALT.
- fetch_err  out  1  controller is in ERROR.
- inst_count  out  32  number of instructions consumed by decode; wraps modulo 2^32.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=FETCH.
  - inst=0, inst_pc=0, inst_count=0.
  - All 1-bit outputs are 0, except im_req, which follows state and is therefore 1.
- States: FETCH, HOLD, HALT, ERROR.
- Outputs by state:
  - im_req=1 only in FETCH.
  - inst_valid=1 only in HOLD.
  - halted=(state==HALT).
  - fetch_err=(state==ERROR).
  - im_addr=pc at all times.
- FETCH:
  - With im_ack=1: inst<=im_rdata, inst_pc<=pc, next state HOLD.
  - With im_ack=0: remain in FETCH, pc held.
  - IM may ack in the same cycle as the request.
  - Latency: the instruction is visible one cycle after the ack cycle.
- HOLD:
  - With inst_ready=1: inst_count<=inst_count+1, pc<=pc+4, next state FETCH.
  - With inst_ready=0: hold inst, inst_pc and pc stable.
- Redirect, accepted in FETCH or HOLD:
  - pc<=redirect_target, next state FETCH.
  - Any im_ack in the same cycle is discarded.
  - A held instruction is squashed (inst_valid=0 next cycle), except when redirect and inst_ready=1 coincide in HOLD: the instruction counts as consumed (inst_count increments), then pc<=redirect_target.
- Halt, accepted in FETCH or HOLD:
  - Next state HALT.
  - inst_count still increments if inst_ready=1 in HOLD that cycle.
  - Halt beats redirect in the same cycle.
  - HALT is left only by reset.
- Range check:
  - Applies to every new pc value (pc+4 or redirect_target).
  - The value traps if addr[1:0]!=0, addr<IM_BASE, or addr>=IM_BASE+4*IM_WORDS.
  - On a trap: pc is still loaded with the value, next state ERROR, no im_req.
  - ERROR is sticky until reset and ignores all inputs.
  - Sequential pc+4 past the last word also traps.
  - Use 33-bit compare arithmetic so the window end does not overflow.
- Priority in a cycle: reset > halt > range error of the selected next pc > redirect > normal sequencing.
- A reset asserted mid-handshake aborts immediately; a late im_ack is ignored.
- Inputs are don't-care in HALT and ERROR.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding fetch_state_t (FETCH, HOLD, HALT, ERROR);
  - constants RESET_PC_DEFAULT=32'h0000_3000 and IM_WORDS_DEFAULT=4096, shared with IM and the CPU top.
- One natural sub-module, pc_range_chk: purely combinational; input addr; output ok; parameters IM_BASE and IM_WORDS.

Test Plan:
- Zero-wait sequential fetch:
  - Stimulus: release reset, im_ack tied 1, inst_ready tied 1.
  - Required: im_addr steps 0x3000, 0x3004, 0x3008; inst_pc follows one cycle behind the ack; inst_count=3 after the third handshake.
- Back-pressure:
  - Stimulus: inst_ready=0 for 5 cycles while inst_valid=1 at inst_pc=0x3004.
  - Required: inst, inst_pc and pc stable; im_req=0; inst_count unchanged; fetch resumes at 0x3008 after ready.
- Redirect with squash:
  - Stimulus: in HOLD at inst_pc=0x300C with inst_ready=0, pulse redirect_target=0x3100.
  - Required: inst_valid=0 next cycle; next im_addr=0x3100; inst_count unchanged.
- Coincident redirect and ready:
  - Stimulus: in HOLD, inst_ready=1 and redirect_target=0x3040 in the same cycle.
  - Required: inst_count increments by 1; next fetch at 0x3040.
- Range and alignment errors:
  - Stimulus: redirect_target=0x3002, then reset; redirect_target=0x2FFC, then reset; sequential run to 0x6FFC.
  - Required: each case reaches fetch_err=1 with im_req=0 thereafter; the pc+4 from 0x6FFC gives pc=0x7000 and ERROR.
- Halt priority:
  - Stimulus: halt=1 and redirect_valid=1 in the same cycle.
  - Required: halted=1 next cycle; im_req=0 forever; pc not reloaded; only reset=0 returns to FETCH at 0x3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch controller state encoding and the memory map
// constants used by the instruction memory, the fetch controller and the CPU top.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2,
        ERROR = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: the IM request/ack channel and the decode valid/ready
// channel. The master modport is the fetch controller's view.
interface fetch_ctrl_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output im_req, im_addr, inst_valid, inst, inst_pc,
        input  im_ack, im_rdata, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst, inst_pc,
        output im_ack, im_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_ctrl_pc_range_chk.sv
// Combinational IM window check for a candidate PC: word aligned and inside
// [IM_BASE, IM_BASE + 4*IM_WORDS). The compare is done on 33 bits so a window
// ending exactly at 2^32 does not wrap to zero.
module pc_range_chk
    import cpu_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic [31:0] addr,
    output logic        ok
);

    localparam logic [32:0] WIN_LO = {1'b0, IM_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

    logic [32:0] addr_x;

    assign addr_x = {1'b0, addr};
    assign ok     = (addr[1:0] == 2'b00) && (addr_x >= WIN_LO) && (addr_x < WIN_HI);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches one word at a time from
// IM, holds it for decode until consumed, and handles redirects, halt and
// out-of-window fetch traps. All status outputs are registered.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    input  logic         halt,
    output logic         halted,
    output logic         fetch_err,
    output logic [31:0]  inst_count
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] next_pc;
    logic        next_ok;
    logic        consume;
    logic        load_pc;
    logic        capture;

    logic        im_req_r;
    logic        inst_valid_r;
    logic        halted_r;
    logic        fetch_err_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_count_r;

    // A redirect always wins over sequencing, so only one candidate PC ever
    // needs checking in a given cycle.
    assign pc_seq  = pc + 32'd4;
    assign next_pc = redirect_valid ? redirect_target : pc_seq;
    assign consume = (state == HOLD) && bus.inst_ready;

    pc_range_chk #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_range_chk (
        .addr (next_pc),
        .ok   (next_ok)
    );

    // Next-state decision: halt, then trap on the new PC, then redirect/sequencing, then capture.
    always_comb begin
        state_nxt = state;
        load_pc   = 1'b0;
        capture   = 1'b0;
        case (state)
            FETCH, HOLD: begin
                if (halt) begin
                    state_nxt = HALT;
                end else if (redirect_valid || consume) begin
                    load_pc   = 1'b1;
                    state_nxt = next_ok ? FETCH : ERROR;
                end else if ((state == FETCH) && bus.im_ack) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // State, PC, held instruction, consumed counter and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            inst_count_r <= 32'd0;
            im_req_r     <= 1'b1;
            inst_valid_r <= 1'b0;
            halted_r     <= 1'b0;
            fetch_err_r  <= 1'b0;
        end else begin
            state        <= state_nxt;
            im_req_r     <= (state_nxt == FETCH);
            inst_valid_r <= (state_nxt == HOLD);
            halted_r     <= (state_nxt == HALT);
            fetch_err_r  <= (state_nxt == ERROR);
            if (load_pc) begin
                pc <= next_pc;
            end
            if (capture) begin
                inst_r    <= bus.im_rdata;
                inst_pc_r <= pc;
            end
            if (consume) begin
                inst_count_r <= inst_count_r + 32'd1;
            end
        end
    end

    assign bus.im_req     = im_req_r;
    assign bus.im_addr    = pc;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = inst_pc_r;
    assign halted         = halted_r;
    assign fetch_err      = fetch_err_r;
    assign inst_count     = inst_count_r;

endmodule
